dzcpu_useq: RTL and testbench

Parametrised microcode sequencer for the dzcpu core. It replaces the purely combinational opcode-to-flow lookup with a clocked engine that owns the micro-PC, fetches micro-ops from an external micro-ROM, and dispatches main-page and 0xCB-page opcodes. It evaluates conditional end-of-flow on Z/C, stalls on memory busy, and optionally vectors to an interrupt flow. It sits between the opcode fetch path and the datapath control decoder.

---
 rtl/dzcpu_useq_pkg.sv | 54 +++++
 rtl/dzcpu_useq_dispatch.sv | 34 +++
 rtl/dzcpu_useq.sv | 163 ++++++++++++++++
 tb/tb_dzcpu_useq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: shared constants for the dzcpu microcode sequencer.
// Holds flow-control codes, FSM state encoding, micro-ROM entry points
// of the main and 0xCB opcode pages, and default field widths.
package dzcpu_useq_pkg;

  localparam int DEF_FLOW_W  = 4;
  localparam int DEF_OP_W    = 5;
  localparam int DEF_OPR_W   = 5;
  localparam int DEF_UADDR_W = 8;

  // Flow-control field of a micro-op. Codes 11..15 are reserved.
  localparam logic [3:0] FL_OP         = 4'd0;
  localparam logic [3:0] FL_INC        = 4'd1;
  localparam logic [3:0] FL_EOF        = 4'd2;
  localparam logic [3:0] FL_INC_EOF    = 4'd3;
  localparam logic [3:0] FL_EOF_FU     = 4'd4;
  localparam logic [3:0] FL_INC_EOF_FU = 4'd5;
  localparam logic [3:0] FL_INC_EOF_Z  = 4'd6;
  localparam logic [3:0] FL_INC_EOF_NZ = 4'd7;
  localparam logic [3:0] FL_INC_EOF_C  = 4'd8;
  localparam logic [3:0] FL_INC_EOF_NC = 4'd9;
  localparam logic [3:0] FL_JCB        = 4'd10;

  // Sequencer states.
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_EXEC    = 2'd1;
  localparam logic [1:0] ST_CBFETCH = 2'd2;

  // Main-page flow entry points (0 doubles as the NOP / unmapped flow).
  localparam logic [7:0] MAIN_NOP   = 8'd0;
  localparam logic [7:0] MAIN_JRNZ  = 8'd1;
  localparam logic [7:0] MAIN_JRC   = 8'd6;
  localparam logic [7:0] MAIN_CB    = 8'd10;
  localparam logic [7:0] MAIN_INCA  = 8'd20;
  localparam logic [7:0] MAIN_HALT  = 8'd24;
  localparam logic [7:0] MAIN_RST38 = 8'd255;

  // 0xCB-page flow entry points.
  localparam logic [7:0] CB_BIT7H   = 8'd16;

  // True when a conditional end-of-flow code sees its condition met.
  function automatic logic cond_hit(input logic [3:0] flow,
                                    input logic       z,
                                    input logic       c);
    case (flow)
      FL_INC_EOF_Z:  return z;
      FL_INC_EOF_NZ: return !z;
      FL_INC_EOF_C:  return c;
      FL_INC_EOF_NC: return !c;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dzcpu_useq_dispatch.sv
// dzcpu_useq_dispatch: opcode-to-micro-ROM-entry lookup, combinational.
// Ports: page (0 = main page, 1 = 0xCB page), mop (opcode byte), entry (micro-ROM address).
// Unmapped opcodes on either page resolve to entry 0.
module dzcpu_useq_dispatch
  import dzcpu_useq_pkg::*;
#(
  parameter int UADDR_W = DEF_UADDR_W
) (
  input  logic               page,
  input  logic [7:0]         mop,
  output logic [UADDR_W-1:0] entry
);

  always_comb begin
    entry = '0;
    if (page) begin
      case (mop)
        8'h7C:   entry = UADDR_W'(CB_BIT7H);
        default: entry = '0;
      endcase
    end else begin
      case (mop)
        8'h20:   entry = UADDR_W'(MAIN_JRNZ);
        8'h38:   entry = UADDR_W'(MAIN_JRC);
        8'hCB:   entry = UADDR_W'(MAIN_CB);
        8'h3C:   entry = UADDR_W'(MAIN_INCA);
        8'h76:   entry = UADDR_W'(MAIN_HALT);
        8'hFF:   entry = UADDR_W'(MAIN_RST38);
        default: entry = UADDR_W'(MAIN_NOP);
      endcase
    end
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: clocked microcode sequencer; owns the micro-PC, dispatches opcodes, issues micro-ops.
// Ports: opcode handshake (iMop/iMopValid/oMopReady), micro-ROM (oUaddr/iUop), flags, stall, irq, issue pulses.
// Optional interrupt vectoring is enabled by defining DZCPU_USEQ_IRQ_EN.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int                 FLOW_W   = DEF_FLOW_W,
  parameter int                 OP_W     = DEF_OP_W,
  parameter int                 OPR_W    = DEF_OPR_W,
  parameter int                 UADDR_W  = DEF_UADDR_W,
  parameter logic [UADDR_W-1:0] IRQ_FLOW = UADDR_W'(121)
) (
  input  logic                          iClock,
  input  logic                          iReset_n,
  input  logic [7:0]                    iMop,
  input  logic                          iMopValid,
  output logic                          oMopReady,
  output logic [UADDR_W-1:0]            oUaddr,
  input  logic [FLOW_W+OP_W+OPR_W-1:0]  iUop,
  input  logic                          iStall,
  input  logic                          iFlagZ,
  input  logic                          iFlagC,
  input  logic                          iIrq,
  output logic                          oUopValid,
  output logic [OP_W-1:0]               oOp,
  output logic [OPR_W-1:0]              oOperand,
  output logic                          oPcInc,
  output logic                          oFlagUpdate,
  output logic                          oEof,
  output logic                          oCbActive,
  output logic                          oIrqAck
);

  localparam int UOP_W = FLOW_W + OP_W + OPR_W;

  logic [1:0]         state, nxt_state;
  logic [UADDR_W-1:0] upc, nxt_upc, entry;
  logic               cb_flow, nxt_cb;
  logic [3:0]         flow;
  logic [OP_W-1:0]    uop_op;
  logic [OPR_W-1:0]   uop_opr;
  logic               iss_vld, iss_inc, iss_fu, iss_eof, iss_ack, go_cb;

  assign flow    = 4'(iUop[UOP_W-1 -: FLOW_W]);
  assign uop_op  = iUop[OP_W+OPR_W-1 -: OP_W];
  assign uop_opr = iUop[OPR_W-1:0];

  assign oUaddr    = upc;
  assign oMopReady = ((state == ST_FETCH) || (state == ST_CBFETCH)) && !iStall;

  dzcpu_useq_dispatch #(.UADDR_W(UADDR_W)) u_dispatch (
    .page  (state == ST_CBFETCH),
    .mop   (iMop),
    .entry (entry)
  );

`ifndef DZCPU_USEQ_IRQ_EN
  logic [UADDR_W:0] unused_irq;
  assign unused_irq = {iIrq, IRQ_FLOW};
`endif

  always_comb begin
    nxt_state = state;
    nxt_upc   = upc;
    nxt_cb    = cb_flow;
    iss_vld   = 1'b0;
    iss_inc   = 1'b0;
    iss_fu    = 1'b0;
    iss_eof   = 1'b0;
    iss_ack   = 1'b0;
    go_cb     = 1'b0;
    if (!iStall) begin
      case (state)
        ST_FETCH: begin
`ifdef DZCPU_USEQ_IRQ_EN
          // Interrupt wins over a simultaneous opcode, which stays pending upstream.
          if (iIrq) begin
            nxt_upc   = IRQ_FLOW;
            iss_ack   = 1'b1;
            nxt_state = ST_EXEC;
          end else
`endif
          if (iMopValid) begin
            nxt_upc   = entry;
            nxt_state = ST_EXEC;
          end
        end
        // Interrupts are not taken here so a CB prefix is never split.
        ST_CBFETCH: begin
          if (iMopValid) begin
            nxt_upc   = entry;
            nxt_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (flow)
            FL_OP:         iss_vld = 1'b1;
            FL_INC:        begin iss_vld = 1'b1; iss_inc = 1'b1; end
            FL_EOF:        begin iss_vld = 1'b1; iss_eof = 1'b1; end
            FL_INC_EOF:    begin iss_vld = 1'b1; iss_inc = 1'b1; iss_eof = 1'b1; end
            FL_EOF_FU:     begin iss_vld = 1'b1; iss_fu = 1'b1; iss_eof = 1'b1; end
            FL_INC_EOF_FU: begin iss_vld = 1'b1; iss_inc = 1'b1; iss_fu = 1'b1; iss_eof = 1'b1; end
            FL_INC_EOF_Z, FL_INC_EOF_NZ, FL_INC_EOF_C, FL_INC_EOF_NC: begin
              // Taken condition ends the flow without executing the op.
              iss_inc = 1'b1;
              if (cond_hit(flow, iFlagZ, iFlagC)) iss_eof = 1'b1;
              else                                iss_vld = 1'b1;
            end
            FL_JCB:        begin iss_inc = 1'b1; go_cb = 1'b1; end
            default:       iss_eof = 1'b1;
          endcase
          if (iss_eof) begin
            nxt_state = ST_FETCH;
            nxt_upc   = '0;
            nxt_cb    = 1'b0;
          end else if (go_cb) begin
            nxt_state = ST_CBFETCH;
            nxt_upc   = '0;
            nxt_cb    = 1'b1;
          end else begin
            nxt_upc = upc + UADDR_W'(1);
          end
        end
        default: begin
          nxt_state = ST_FETCH;
          nxt_upc   = '0;
          nxt_cb    = 1'b0;
        end
      endcase
    end
  end

  // All state and outputs are frozen while iStall is high, so a pulse is never re-issued.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= ST_FETCH;
      upc         <= '0;
      cb_flow     <= 1'b0;
      oUopValid   <= 1'b0;
      oOp         <= '0;
      oOperand    <= '0;
      oPcInc      <= 1'b0;
      oFlagUpdate <= 1'b0;
      oEof        <= 1'b0;
      oCbActive   <= 1'b0;
      oIrqAck     <= 1'b0;
    end else if (!iStall) begin
      state       <= nxt_state;
      upc         <= nxt_upc;
      cb_flow     <= nxt_cb;
      oUopValid   <= iss_vld;
      oOp         <= iss_vld ? uop_op  : '0;
      oOperand    <= iss_vld ? uop_opr : '0;
      oPcInc      <= iss_inc;
      oFlagUpdate <= iss_fu;
      oEof        <= iss_eof;
      // Covers the CB flow through the cycle showing its final micro-op.
      oCbActive   <= cb_flow | nxt_cb;
      oIrqAck     <= iss_ack;
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: directed bench for dzcpu_useq with a small micro-ROM model.
// Each task drives a per-cycle stimulus table and compares all outputs every cycle.
// Interrupt expectations follow DZCPU_USEQ_IRQ_EN.
module tb_dzcpu_useq;
  import dzcpu_useq_pkg::*;

  typedef struct packed {
    logic       rst_n;
    logic [7:0] mop;
    logic       vld;
    logic       stall;
    logic       z;
    logic       c;
    logic       irq;
  } stim_t;

  typedef struct packed {
    logic       rdy;
    logic [7:0] ua;
    logic       vld;
    logic [4:0] op;
    logic [4:0] opr;
    logic       inc;
    logic       fu;
    logic       eof;
    logic       cb;
    logic       ack;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n, mop_vld, stall, flag_z, flag_c, irq;
  logic [7:0]  mop;
  logic        mop_ready, uop_valid, pc_inc, flag_update, eof, cb_active, irq_ack;
  logic [7:0]  uaddr;
  logic [13:0] uop;
  logic [4:0]  op, operand;
  logic [13:0] rom [256];
  obs_t        obs;
  int          checks, failures;

  always #5 clk = ~clk;

  always_comb uop = rom[uaddr];
  assign obs = {mop_ready, uaddr, uop_valid, op, operand, pc_inc, flag_update, eof, cb_active, irq_ack};

  dzcpu_useq dut (
    .iClock(clk), .iReset_n(rst_n), .iMop(mop), .iMopValid(mop_vld), .oMopReady(mop_ready),
    .oUaddr(uaddr), .iUop(uop), .iStall(stall), .iFlagZ(flag_z), .iFlagC(flag_c), .iIrq(irq),
    .oUopValid(uop_valid), .oOp(op), .oOperand(operand), .oPcInc(pc_inc),
    .oFlagUpdate(flag_update), .oEof(eof), .oCbActive(cb_active), .oIrqAck(irq_ack)
  );

  function automatic stim_t sv(input int m, input int v, input int z, input int c,
                               input int i, input int s, input int r);
    stim_t t;
    t.mop = 8'(m); t.vld = 1'(v); t.z = 1'(z); t.c = 1'(c);
    t.irq = 1'(i); t.stall = 1'(s); t.rst_n = 1'(r);
    return t;
  endfunction

  function automatic stim_t nop_s();
    return sv(0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic stim_t acc(input int m);
    return sv(m, 1, 0, 0, 0, 0, 1);
  endfunction

  function automatic obs_t ob(input int rdy, input int ua, input int vld, input int o,
                              input int opr, input int inc, input int fu, input int e,
                              input int cb, input int ack);
    obs_t t;
    t.rdy = 1'(rdy); t.ua = 8'(ua); t.vld = 1'(vld); t.op = 5'(o); t.opr = 5'(opr);
    t.inc = 1'(inc); t.fu = 1'(fu); t.eof = 1'(e); t.cb = 1'(cb); t.ack = 1'(ack);
    return t;
  endfunction

  function automatic obs_t idle_o();
    return ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic obs_t busy(input int ua);
    return ob(0, ua, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; mop = s.mop; mop_vld = s.vld; stall = s.stall;
    flag_z = s.z; flag_c = s.c; irq = s.irq;
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    st = '{sv(8'h20, 1, 0, 0, 1, 0, 0), sv(8'h20, 1, 0, 0, 1, 0, 0), nop_s(), nop_s()};
    ex = '{idle_o(), idle_o(), idle_o(), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    obs_t  ex[$];
    st = '{acc(8'h00), nop_s(), acc(8'h00), nop_s(), nop_s(), nop_s()};
    ex = '{idle_o(), busy(0), ob(1, 0, 1, 1, 0, 1, 0, 1, 0, 0), busy(0),
           ob(1, 0, 1, 1, 0, 1, 0, 1, 0, 0), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL nop_b2b cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cond();
    stim_t st[$];
    obs_t  ex[$];
    // JR NZ with Z=1 ends at once; with Z=0 runs three more micro-ops.
    // JR C with C=0 ends at once; with C=1 runs one more micro-op.
    st = '{acc(8'h20), sv(0, 0, 1, 0, 0, 0, 1), nop_s(), nop_s(),
           acc(8'h20), nop_s(), nop_s(), nop_s(), nop_s(), nop_s(), nop_s(),
           acc(8'h38), nop_s(), nop_s(), nop_s(),
           acc(8'h38), sv(0, 0, 0, 1, 0, 0, 1), nop_s(), nop_s(), nop_s()};
    ex = '{idle_o(), busy(1), ob(1, 0, 0, 0, 0, 1, 0, 1, 0, 0), idle_o(),
           idle_o(), busy(1), ob(0, 2, 1, 2, 1, 1, 0, 0, 0, 0), ob(0, 3, 1, 3, 4, 0, 0, 0, 0, 0),
           ob(0, 4, 1, 4, 5, 0, 0, 0, 0, 0), ob(1, 0, 1, 5, 6, 0, 0, 1, 0, 0), idle_o(),
           idle_o(), busy(6), ob(1, 0, 0, 0, 0, 1, 0, 1, 0, 0), idle_o(),
           idle_o(), busy(6), ob(0, 7, 1, 13, 14, 1, 0, 0, 0, 0), ob(1, 0, 1, 14, 15, 0, 0, 1, 0, 0),
           idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL cond cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cb();
    stim_t st[$];
    obs_t  ex[$];
    // irq raised during CBFETCH must never be taken.
    st = '{acc(8'hCB), nop_s(), sv(8'h7C, 1, 0, 0, 1, 0, 1), nop_s(), nop_s(), nop_s(), nop_s()};
    ex = '{idle_o(), busy(10), ob(1, 0, 0, 0, 0, 1, 0, 0, 1, 0), ob(0, 16, 0, 0, 0, 0, 0, 0, 1, 0),
           ob(0, 17, 1, 6, 7, 0, 0, 0, 1, 0), ob(1, 0, 1, 7, 8, 0, 1, 1, 1, 0), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL cb_page cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  held;
    held = ob(0, 3, 1, 3, 4, 0, 0, 0, 0, 0);
    st = '{acc(8'h20), nop_s(), nop_s(), sv(0, 0, 0, 0, 0, 1, 1), sv(0, 0, 0, 0, 0, 1, 1),
           sv(0, 0, 0, 0, 0, 1, 1), nop_s(), nop_s(), nop_s(), sv(8'h00, 1, 0, 0, 0, 1, 1), nop_s()};
    ex = '{idle_o(), busy(1), ob(0, 2, 1, 2, 1, 1, 0, 0, 0, 0), held, held, held, held,
           ob(0, 4, 1, 4, 5, 0, 0, 0, 0, 0), ob(1, 0, 1, 5, 6, 0, 0, 1, 0, 0), busy(0), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL stall cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flows();
    stim_t st[$];
    obs_t  ex[$];
    // Reserved flow code, flag-update flow, and micro-PC wrap from 255 to 0.
    st = '{acc(8'h76), nop_s(), nop_s(), nop_s(),
           acc(8'h3C), nop_s(), nop_s(), nop_s(),
           acc(8'hFF), nop_s(), nop_s(), nop_s(), nop_s()};
    ex = '{idle_o(), busy(24), ob(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), idle_o(),
           idle_o(), busy(20), ob(1, 0, 1, 8, 9, 1, 1, 1, 0, 0), idle_o(),
           idle_o(), busy(255), ob(0, 0, 1, 12, 13, 1, 0, 0, 0, 0),
           ob(1, 0, 1, 1, 0, 1, 0, 1, 0, 0), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL flows cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_irq();
    stim_t st[$];
    obs_t  ex[$];
    st = '{sv(8'h00, 1, 0, 0, 1, 0, 1), nop_s(), nop_s(), nop_s(), nop_s()};
`ifdef DZCPU_USEQ_IRQ_EN
    ex = '{idle_o(), ob(0, 121, 0, 0, 0, 0, 0, 0, 0, 1), ob(0, 122, 1, 10, 11, 0, 0, 0, 0, 0),
           ob(1, 0, 1, 11, 12, 0, 0, 1, 0, 0), idle_o()};
`else
    ex = '{idle_o(), busy(0), ob(1, 0, 1, 1, 0, 1, 0, 1, 0, 0), idle_o(), idle_o()};
`endif
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL irq cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflow();
    stim_t st[$];
    obs_t  ex[$];
    st = '{acc(8'h20), nop_s(), nop_s(), sv(0, 0, 0, 0, 0, 0, 0), acc(8'h00), nop_s(), nop_s(), nop_s()};
    ex = '{idle_o(), busy(1), ob(0, 2, 1, 2, 1, 1, 0, 0, 0, 0), idle_o(), idle_o(), busy(0),
           ob(1, 0, 1, 1, 0, 1, 0, 1, 0, 0), idle_o()};
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL reset_mid cyc%0d got=%h want=%h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {FL_EOF, 5'd31, 5'd31};
    rom[0]   = {FL_INC_EOF,    5'd1,  5'd0};
    rom[1]   = {FL_INC_EOF_Z,  5'd2,  5'd1};
    rom[2]   = {FL_OP,         5'd3,  5'd4};
    rom[3]   = {FL_OP,         5'd4,  5'd5};
    rom[4]   = {FL_EOF,        5'd5,  5'd6};
    rom[6]   = {FL_INC_EOF_NC, 5'd13, 5'd14};
    rom[7]   = {FL_EOF,        5'd14, 5'd15};
    rom[10]  = {FL_JCB,        5'd0,  5'd0};
    rom[16]  = {FL_OP,         5'd6,  5'd7};
    rom[17]  = {FL_EOF_FU,     5'd7,  5'd8};
    rom[20]  = {FL_INC_EOF_FU, 5'd8,  5'd9};
    rom[24]  = {4'd12,         5'd9,  5'd10};
    rom[121] = {FL_OP,         5'd10, 5'd11};
    rom[122] = {FL_EOF,        5'd11, 5'd12};
    rom[255] = {FL_INC,        5'd12, 5'd13};
    checks   = 0;
    failures = 0;
    apply(sv(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_cond();
    test_cb();
    test_stall();
    test_flows();
    test_irq();
    test_reset_midflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
